// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file writeback controller.
// Provides the register-file geometry, the arbitration grant encoding, the
// writeback request bundle, and a one-hot helper used by the scoreboard.
package regfile_ctrl_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LSU  = 2'd2
  } grant_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       rd_data;
  } wb_req_t;

  // One-hot register mask for a register index.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] one;
    one = {{(NUM_REGS-1){1'b0}}, 1'b1};
    return one << addr;
  endfunction

endpackage

// File: rtl/wb_arbiter.sv
// Two-input writeback arbiter (ALU vs LSU).
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_alu_valid        ALU writeback request
//   i_lsu_valid        LSU writeback request
//   o_grant            combinational grant (GNT_NONE while in reset)
// RR_MODE=1: on conflict the loser of the previous conflict wins.
// RR_MODE=0: LSU wins conflicts, but after STARVE_MAX consecutive ALU losses
//            the ALU receives a forced grant.
module wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int RR_MODE    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_alu_valid,
  input  logic   i_lsu_valid,
  output grant_e o_grant
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // rr_lsu_pref: 0 = ALU wins the next conflict, 1 = LSU wins it
  logic       rr_lsu_pref_d, rr_lsu_pref_q;
  logic [3:0] starve_cnt_d, starve_cnt_q;
  grant_e     grant;

  // Grant selection plus pointer/counter next-state
  always_comb begin
    grant         = GNT_NONE;
    rr_lsu_pref_d = rr_lsu_pref_q;
    starve_cnt_d  = starve_cnt_q;
    if (i_rst) begin
      grant = GNT_NONE;
    end else begin
      case ({i_alu_valid, i_lsu_valid})
        2'b10: grant = GNT_ALU;
        2'b01: grant = GNT_LSU;
        2'b11: begin
          if (RR_MODE != 0) begin
            grant         = rr_lsu_pref_q ? GNT_LSU : GNT_ALU;
            // Pointer moves only on conflict cycles: winner goes to the back.
            rr_lsu_pref_d = ~rr_lsu_pref_q;
          end else if (starve_cnt_q >= STARVE_LIM) begin
            grant = GNT_ALU;
          end else begin
            grant = GNT_LSU;
          end
        end
        default: grant = GNT_NONE;
      endcase
      // Counts consecutive ALU losses; any ALU grant or idle ALU clears it.
      if ((RR_MODE == 0) && i_alu_valid && (grant == GNT_LSU)) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end else begin
        starve_cnt_d = 4'd0;
      end
    end
  end

  // Arbitration state registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_lsu_pref_q <= 1'b0;
      starve_cnt_q  <= 4'd0;
    end else begin
      rr_lsu_pref_q <= rr_lsu_pref_d;
      starve_cnt_q  <= starve_cnt_d;
    end
  end

  assign o_grant = grant;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller in front of the single register-file write port.
// Ports:
//   i_clk, i_rst                       clock, asynchronous active-high reset
//   i_alu_*/o_alu_ready                ALU writeback valid/ready request
//   i_lsu_*/o_lsu_ready                LSU writeback valid/ready request
//   i_issue_valid, i_issue_rd_addr     decode reserves rd (sets busy bit)
//   i_rs1_addr/i_rs2_addr, o_rs*_busy  RAW hazard lookup
//   o_busy_mask                        full pending-write scoreboard
//   o_rd_wren/o_rd_addr/o_rd_data      registered regfile write port
module regfile_wb_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int RR_MODE    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_alu_valid,
  output logic        o_alu_ready,
  input  logic [4:0]  i_alu_rd_addr,
  input  logic [31:0] i_alu_rd_data,
  input  logic        i_lsu_valid,
  output logic        o_lsu_ready,
  input  logic [4:0]  i_lsu_rd_addr,
  input  logic [31:0] i_lsu_rd_data,
  input  logic        i_issue_valid,
  input  logic [4:0]  i_issue_rd_addr,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic        o_rs1_busy,
  output logic        o_rs2_busy,
  output logic [31:0] o_busy_mask,
  output logic        o_rd_wren,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data
);

  grant_e                grant;
  wb_req_t               alu_req, lsu_req, sel_req;
  logic                  rd_wren_d, rd_wren_q;
  logic [REG_ADDR_W-1:0] rd_addr_d, rd_addr_q;
  logic [XLEN-1:0]       rd_data_d, rd_data_q;
  logic [NUM_REGS-1:0]   busy_d, busy_q;

  assign alu_req = '{valid: i_alu_valid, rd_addr: i_alu_rd_addr, rd_data: i_alu_rd_data};
  assign lsu_req = '{valid: i_lsu_valid, rd_addr: i_lsu_rd_addr, rd_data: i_lsu_rd_data};

  wb_arbiter #(
    .RR_MODE    (RR_MODE),
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_alu_valid (i_alu_valid),
    .i_lsu_valid (i_lsu_valid),
    .o_grant     (grant)
  );

  assign o_alu_ready = (grant == GNT_ALU);
  assign o_lsu_ready = (grant == GNT_LSU);

  // Output stage next-state: load the granted request; x0 is consumed silently
  always_comb begin
    sel_req   = '0;
    rd_wren_d = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    case (grant)
      GNT_ALU: sel_req = alu_req;
      GNT_LSU: sel_req = lsu_req;
      default: sel_req = '0;
    endcase
    if (sel_req.valid) begin
      rd_wren_d = (sel_req.rd_addr != 5'd0);
      rd_addr_d = sel_req.rd_addr;
      rd_data_d = sel_req.rd_data;
    end else begin
      rd_wren_d = 1'b0;
    end
  end

  // Scoreboard next-state: clear on commit first, then set on issue so a
  // same-register set/clear collision leaves the newer producer pending
  always_comb begin
    busy_d = busy_q;
    if (rd_wren_q) begin
      busy_d = busy_d & ~reg_onehot(rd_addr_q);
    end else begin
      busy_d = busy_q;
    end
    if (i_issue_valid && (i_issue_rd_addr != 5'd0)) begin
      busy_d = busy_d | reg_onehot(i_issue_rd_addr);
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Output stage and scoreboard registers; reset drops any held write
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_wren_q <= 1'b0;
      rd_addr_q <= 5'd0;
      rd_data_q <= 32'd0;
      busy_q    <= 32'd0;
    end else begin
      rd_wren_q <= rd_wren_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
    end
  end

  assign o_rd_wren   = rd_wren_q;
  assign o_rd_addr   = rd_addr_q;
  assign o_rd_data   = rd_data_q;
  assign o_busy_mask = busy_q;
  assign o_rs1_busy  = busy_q[i_rs1_addr];
  assign o_rs2_busy  = busy_q[i_rs2_addr];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: instance 0 runs round-robin, instance 1 runs
// fixed LSU priority with STARVE_MAX=4. A reference model predicts grants,
// committed writes and the busy mask; expected writes are queued and a
// separate monitor pops them when the DUT asserts its write enable.
module tb_regfile_wb_ctrl;

  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       alu_valid, lsu_valid, issue_valid;
  logic [1:0]       alu_ready, lsu_ready, rs1_busy, rs2_busy, rd_wren;
  logic [1:0][4:0]  alu_addr, lsu_addr, issue_addr, rs1_addr, rs2_addr, rd_addr;
  logic [1:0][31:0] alu_data, lsu_data, busy_mask, rd_data;

  regfile_wb_ctrl #(.RR_MODE(1), .STARVE_MAX(STARVE)) dut_rr (
    .i_clk(clk), .i_rst(rst),
    .i_alu_valid(alu_valid[0]), .o_alu_ready(alu_ready[0]),
    .i_alu_rd_addr(alu_addr[0]), .i_alu_rd_data(alu_data[0]),
    .i_lsu_valid(lsu_valid[0]), .o_lsu_ready(lsu_ready[0]),
    .i_lsu_rd_addr(lsu_addr[0]), .i_lsu_rd_data(lsu_data[0]),
    .i_issue_valid(issue_valid[0]), .i_issue_rd_addr(issue_addr[0]),
    .i_rs1_addr(rs1_addr[0]), .i_rs2_addr(rs2_addr[0]),
    .o_rs1_busy(rs1_busy[0]), .o_rs2_busy(rs2_busy[0]),
    .o_busy_mask(busy_mask[0]),
    .o_rd_wren(rd_wren[0]), .o_rd_addr(rd_addr[0]), .o_rd_data(rd_data[0])
  );

  regfile_wb_ctrl #(.RR_MODE(0), .STARVE_MAX(STARVE)) dut_fx (
    .i_clk(clk), .i_rst(rst),
    .i_alu_valid(alu_valid[1]), .o_alu_ready(alu_ready[1]),
    .i_alu_rd_addr(alu_addr[1]), .i_alu_rd_data(alu_data[1]),
    .i_lsu_valid(lsu_valid[1]), .o_lsu_ready(lsu_ready[1]),
    .i_lsu_rd_addr(lsu_addr[1]), .i_lsu_rd_data(lsu_data[1]),
    .i_issue_valid(issue_valid[1]), .i_issue_rd_addr(issue_addr[1]),
    .i_rs1_addr(rs1_addr[1]), .i_rs2_addr(rs2_addr[1]),
    .o_rs1_busy(rs1_busy[1]), .o_rs2_busy(rs2_busy[1]),
    .o_busy_mask(busy_mask[1]),
    .o_rd_wren(rd_wren[1]), .o_rd_addr(rd_addr[1]), .o_rd_data(rd_data[1])
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          edge_n;
  } wb_t;

  wb_t q0[$];
  wb_t q1[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  // Reference model state, one slot per instance
  bit          m_last_alu [2];  // last conflict winner was the ALU
  int          m_losses [2];    // consecutive ALU conflict losses
  logic [31:0] m_busy [2];      // registers with an outstanding producer
  bit          m_cv [2];        // a write was accepted and is in flight
  logic [4:0]  m_ca [2];
  bit          acc_alu [2];
  bit          acc_lsu [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc=%0d actual=%h expected=%h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_last_alu[k] = 1'b0;
      m_losses[k]   = 0;
      m_busy[k]     = 32'd0;
      m_cv[k]       = 1'b0;
      m_ca[k]       = 5'd0;
      acc_alu[k]    = 1'b0;
      acc_lsu[k]    = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Called at a negedge with inputs already applied; predicts this cycle.
  task automatic step();
    #1;
    for (int k = 0; k < 2; k++) begin
      int          g;
      logic [31:0] nb;
      logic [4:0]  ra;
      logic [31:0] rdat;
      wb_t         e;
      g = 0;
      if (alu_valid[k] && !lsu_valid[k]) g = 1;
      else if (!alu_valid[k] && lsu_valid[k]) g = 2;
      else if (alu_valid[k] && lsu_valid[k]) begin
        if (k == 0) g = m_last_alu[k] ? 2 : 1;
        else        g = (m_losses[k] >= STARVE) ? 1 : 2;
      end
      check("alu_ready", k, 32'(alu_ready[k]), 32'(g == 1));
      check("lsu_ready", k, 32'(lsu_ready[k]), 32'(g == 2));
      check("rs1_busy", k, 32'(rs1_busy[k]), 32'(m_busy[k][rs1_addr[k]]));
      check("rs2_busy", k, 32'(rs2_busy[k]), 32'(m_busy[k][rs2_addr[k]]));
      if (k == 0) begin
        if (alu_valid[k] && lsu_valid[k]) m_last_alu[k] = (g == 1);
      end else begin
        if (alu_valid[k] && g == 2) m_losses[k] = m_losses[k] + 1;
        else m_losses[k] = 0;
      end
      nb = m_busy[k];
      if (m_cv[k]) nb[m_ca[k]] = 1'b0;
      if (issue_valid[k] && issue_addr[k] != 5'd0) nb[issue_addr[k]] = 1'b1;
      nb[0] = 1'b0;
      m_busy[k] = nb;
      acc_alu[k] = (g == 1);
      acc_lsu[k] = (g == 2);
      ra   = (g == 1) ? alu_addr[k] : lsu_addr[k];
      rdat = (g == 1) ? alu_data[k] : lsu_data[k];
      m_cv[k] = (g != 0) && (ra != 5'd0);
      m_ca[k] = ra;
      if (m_cv[k]) begin
        e.addr = ra; e.data = rdat; e.edge_n = cyc + 1;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic mon_one(input int k);
    wb_t e;
    int  n;
    n = (k == 0) ? q0.size() : q1.size();
    if (n > 0) e = (k == 0) ? q0[0] : q1[0];
    check("busy_mask", k, busy_mask[k], m_busy[k]);
    if (rd_wren[k]) begin
      if (n == 0) begin
        check("unexpected_wren", k, 32'd1, 32'd0);
      end else begin
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        check("rd_addr", k, 32'(rd_addr[k]), 32'(e.addr));
        check("rd_data", k, rd_data[k], e.data);
        check("wr_latency_edge", k, cyc, e.edge_n);
      end
    end else if (n > 0 && e.edge_n <= cyc) begin
      if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      check("missing_wren", k, 32'd0, 32'd1);
    end
  endtask

  // Monitor: samples DUT outputs just after each rising edge
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      mon_one(0);
      mon_one(1);
    end
  end

  task automatic drive(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld,
                       input bit iv, input logic [4:0] ia, input logic [4:0] r1);
    for (int k = 0; k < 2; k++) begin
      alu_valid[k] = av; alu_addr[k] = aa; alu_data[k] = ad;
      lsu_valid[k] = lv; lsu_addr[k] = la; lsu_data[k] = ld;
      issue_valid[k] = iv; issue_addr[k] = ia;
      rs1_addr[k] = r1; rs2_addr[k] = aa;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_wren", k, 32'(rd_wren[k]), 32'd0);
      check("rst_busy", k, busy_mask[k], 32'd0);
      check("rst_alu_ready", k, 32'(alu_ready[k]), 32'd0);
      check("rst_lsu_ready", k, 32'(lsu_ready[k]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    do_reset();
    for (int k = 0; k < 2; k++) check("reset_addr", k, 32'(rd_addr[k]), 32'd0);
    mon_en = 1'b1;

    // Reserve r5, then ALU writes it back
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5);
    step();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5);
    step();
    step();

    // Both requesters continuously valid
    drive(1'b1, 5'd1, 32'h1111_0001, 1'b1, 5'd2, 32'h2222_0002, 1'b0, 5'd0, 5'd1);
    for (int i = 0; i < 7; i++) step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    step();

    // Write to x0 is accepted but never reaches the port
    drive(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    step();

    // Issue r7 on the same edge r7 commits: stays busy
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7);
    step();
    drive(1'b1, 5'd7, 32'h0000_0777, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7);
    step();

    // Reset asserted while an accepted write sits in the output stage
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9);
    step();
    drive(1'b1, 5'd9, 32'h9999_0009, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9);
    step();
    drive(1'b1, 5'd10, 32'hAAAA_000A, 1'b1, 5'd11, 32'hBBBB_000B, 1'b0, 5'd0, 5'd9);
    do_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9);
    step();

    // Randomized traffic, each instance with independent requesters
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!alu_valid[k] || acc_alu[k]) begin
          alu_valid[k] = ($urandom_range(0, 3) != 0);
          alu_addr[k]  = 5'($urandom_range(0, 31));
          alu_data[k]  = $urandom;
        end
        if (!lsu_valid[k] || acc_lsu[k]) begin
          lsu_valid[k] = ($urandom_range(0, 2) != 0);
          lsu_addr[k]  = 5'($urandom_range(0, 31));
          lsu_data[k]  = $urandom;
        end
        issue_valid[k] = ($urandom_range(0, 2) == 0);
        issue_addr[k]  = 5'($urandom_range(0, 31));
        rs1_addr[k]    = 5'($urandom_range(0, 31));
        rs2_addr[k]    = 5'($urandom_range(0, 31));
      end
      step();
    end

    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) step();
    check("queue_drain", 0, 32'(q0.size()), 32'd0);
    check("queue_drain", 1, 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
